// File: rtl/key_event_encoder.sv
// key_event_encoder: turns two debounced key levels into press / release /
// long-press / auto-repeat events and queues them in a 4-entry FIFO.
//
// Build option: define KEY_REPEAT_EN to compile in auto-repeat events
// (code 3) while a key stays in HELD; without it HELD is silent.
//
// Ports:
//   sysClk      in   sole clock, rising edge
//   sysRst      in   asynchronous active-low reset
//   stableKey   in   [1:0] debounced key levels, 1 = pressed
//   evtValid    out  FIFO head holds an event
//   evtReady    in   consumer accepts the head event
//   evtKey      out  key index of the head event
//   evtCode     out  [1:0] 0 press, 1 release, 2 long, 3 repeat
//   evtOverflow out  sticky, an event was dropped (cleared by reset only)
module key_event_encoder #(
   parameter int unsigned CYCLES_PER_MS = 50000,
   parameter int unsigned LONG_PRESS_MS = 1000,
   parameter int unsigned REPEAT_MS     = 200
) (
   input  logic       sysClk,
   input  logic       sysRst,
   input  logic [1:0] stableKey,
   output logic       evtValid,
   input  logic       evtReady,
   output logic       evtKey,
   output logic [1:0] evtCode,
   output logic       evtOverflow
);

   localparam int unsigned NKEYS  = 2;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PTR_W  = 2;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned HOLD_W = 32;
   localparam int unsigned ENT_W  = 3;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESSED = 2'd1;
   localparam logic [1:0] ST_HELD    = 2'd2;

   localparam logic [1:0] CODE_PRESS   = 2'd0;
   localparam logic [1:0] CODE_RELEASE = 2'd1;
   localparam logic [1:0] CODE_LONG    = 2'd2;

   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_MS * CYCLES_PER_MS - 1);

`ifdef KEY_REPEAT_EN
   localparam logic [1:0]        CODE_REPEAT = 2'd3;
   localparam logic [HOLD_W-1:0] REP_LAST    = HOLD_W'(REPEAT_MS * CYCLES_PER_MS - 1);
`else
   // Repeat period has no meaning in this build.
   logic unused_repeat_c;
   assign unused_repeat_c = ^HOLD_W'(REPEAT_MS);
`endif

   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DEPTH);

   logic [NKEYS-1:0][1:0]        state_q, state_d;
   logic [NKEYS-1:0][HOLD_W-1:0] hold_q, hold_d;
   logic [NKEYS-1:0]             prev_q;
   logic [NKEYS-1:0]             pend_vld_q, pend_vld_d;
   logic [NKEYS-1:0][1:0]        pend_code_q, pend_code_d;
   logic [DEPTH-1:0][ENT_W-1:0]  fifo_q, fifo_d;
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic                         overflow_q, overflow_d;

   logic [NKEYS-1:0]             ev_vld_c;
   logic [NKEYS-1:0][1:0]        ev_code_c;
   logic                         full_c, empty_c, push_c, pop_c, push_key_c;
   logic [NKEYS-1:0]             drain_c;

   // Per-key state machine: release wins over any threshold on the same edge.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      ev_vld_c  = '0;
      ev_code_c = '0;
      for (int unsigned k = 0; k < NKEYS; k++) begin
         if (state_q[k] != ST_IDLE && !stableKey[k] && prev_q[k]) begin
            ev_vld_c[k]  = 1'b1;
            ev_code_c[k] = CODE_RELEASE;
            state_d[k]   = ST_IDLE;
            hold_d[k]    = '0;
         end else if (state_q[k] == ST_IDLE && stableKey[k] && !prev_q[k]) begin
            ev_vld_c[k]  = 1'b1;
            ev_code_c[k] = CODE_PRESS;
            state_d[k]   = ST_PRESSED;
            hold_d[k]    = '0;
         end else if (state_q[k] == ST_PRESSED) begin
            if (hold_q[k] == LONG_LAST) begin
               ev_vld_c[k]  = 1'b1;
               ev_code_c[k] = CODE_LONG;
               state_d[k]   = ST_HELD;
               hold_d[k]    = '0;
            end else begin
               hold_d[k] = hold_q[k] + HOLD_W'(1);
            end
         end
`ifdef KEY_REPEAT_EN
         else if (state_q[k] == ST_HELD) begin
            if (hold_q[k] == REP_LAST) begin
               ev_vld_c[k]  = 1'b1;
               ev_code_c[k] = CODE_REPEAT;
               hold_d[k]    = '0;
            end else begin
               hold_d[k] = hold_q[k] + HOLD_W'(1);
            end
         end
`endif
      end
   end

   // FIFO control; a slot drained on this edge may accept a new event.
   always_comb begin
      full_c     = (count_q == FIFO_FULL);
      empty_c    = (count_q == '0);
      pop_c      = !empty_c && evtReady;
      push_c     = !full_c && (|pend_vld_q);
      push_key_c = !pend_vld_q[0];
      drain_c    = '0;
      if (push_c) begin
         drain_c = pend_vld_q[0] ? 2'b01 : 2'b10;
      end

      pend_vld_d  = pend_vld_q & ~drain_c;
      pend_code_d = pend_code_q;
      overflow_d  = overflow_q;
      for (int unsigned k = 0; k < NKEYS; k++) begin
         if (ev_vld_c[k]) begin
            if (!pend_vld_q[k] || drain_c[k]) begin
               pend_vld_d[k]  = 1'b1;
               pend_code_d[k] = ev_code_c[k];
            end else begin
               overflow_d = 1'b1;
            end
         end
      end

      fifo_d = fifo_q;
      if (push_c) begin
         fifo_d[wr_ptr_q] = {push_key_c, pend_code_q[push_key_c]};
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
      count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
   end

   always_ff @(posedge sysClk or negedge sysRst) begin
      if (!sysRst) begin
         state_q     <= '0;
         hold_q      <= '0;
         prev_q      <= '0;
         pend_vld_q  <= '0;
         pend_code_q <= '0;
         fifo_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         prev_q      <= stableKey;
         pend_vld_q  <= pend_vld_d;
         pend_code_q <= pend_code_d;
         fifo_q      <= fifo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

   // Head entry is presented straight from the FIFO storage.
   assign evtValid    = !empty_c;
   assign evtKey      = fifo_q[rd_ptr_q][2];
   assign evtCode     = fifo_q[rd_ptr_q][1:0];
   assign evtOverflow = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with CYCLES_PER_MS=10, LONG_PRESS_MS=3,
// REPEAT_MS=2 (long after 30 held cycles, repeat every 20 cycles).
module tb_key_event_encoder;

   logic       sysClk = 1'b0;
   logic       sysRst;
   logic [1:0] stableKey;
   logic       evtValid;
   logic       evtReady;
   logic       evtKey;
   logic [1:0] evtCode;
   logic       evtOverflow;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;

   // Log of accepted events: key, code and clock-edge count when accepted.
   int         n_log = 0;
   logic       lk [64];
   logic [1:0] lc [64];
   int         lt [64];

   key_event_encoder #(
      .CYCLES_PER_MS(10),
      .LONG_PRESS_MS(3),
      .REPEAT_MS(2)
   ) dut (
      .sysClk(sysClk),
      .sysRst(sysRst),
      .stableKey(stableKey),
      .evtValid(evtValid),
      .evtReady(evtReady),
      .evtKey(evtKey),
      .evtCode(evtCode),
      .evtOverflow(evtOverflow)
   );

   always #5 sysClk = ~sysClk;

   always @(posedge sysClk) cyc++;

   always @(negedge sysClk) begin
      if (sysRst && evtValid && evtReady && n_log < 64) begin
         lk[n_log] = evtKey;
         lc[n_log] = evtCode;
         lt[n_log] = cyc;
         n_log++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sysClk);
         #1;
      end
   endtask

   task automatic test_reset;
      sysRst = 1'b0; stableKey = 2'b00; evtReady = 1'b1;
      #12;
      total_cnt++;
      if ({evtValid, evtOverflow, evtKey, evtCode} !== 5'b0) begin
         $display("FAIL reset_outputs: got %b want 00000", {evtValid, evtOverflow, evtKey, evtCode});
      end else pass_cnt++;
      tick(2);
      sysRst = 1'b1;
      tick(3);
      total_cnt++;
      if (evtValid !== 1'b0) begin
         $display("FAIL idle_after_reset: evtValid got %b want 0", evtValid);
      end else pass_cnt++;
   endtask

   task automatic test_short_press;
      int base;
      base = n_log;
      stableKey[0] = 1'b1;
      tick(1);
      total_cnt++;
      if (evtValid !== 1'b0) begin
         $display("FAIL latency_pending: evtValid got %b want 0", evtValid);
      end else pass_cnt++;
      tick(1);
      total_cnt++;
      if ({evtValid, evtKey, evtCode} !== 4'b1_0_00) begin
         $display("FAIL latency_head: got %b want 1000", {evtValid, evtKey, evtCode});
      end else pass_cnt++;
      tick(3);
      stableKey[0] = 1'b0;
      tick(6);
      total_cnt++;
      if (n_log - base !== 2) begin
         $display("FAIL short_count: got %0d want 2", n_log - base);
      end else pass_cnt++;
      total_cnt++;
      if ({lk[base], lc[base], lk[base+1], lc[base+1]} !== 6'b0_00_0_01) begin
         $display("FAIL short_events: got %b want 000001", {lk[base], lc[base], lk[base+1], lc[base+1]});
      end else pass_cnt++;
   endtask

   task automatic test_long_repeat;
      int base;
      base = n_log;
      stableKey[1] = 1'b1;
      tick(60);
      stableKey[1] = 1'b0;
      tick(6);
`ifdef KEY_REPEAT_EN
      total_cnt++;
      if (n_log - base !== 4) begin
         $display("FAIL long_count: got %0d want 4", n_log - base);
      end else pass_cnt++;
      total_cnt++;
      if ({lk[base], lc[base], lk[base+1], lc[base+1], lk[base+2], lc[base+2], lk[base+3], lc[base+3]}
          !== 12'b1_00_1_10_1_11_1_01) begin
         $display("FAIL long_events: got %b want 100110111101",
                  {lk[base], lc[base], lk[base+1], lc[base+1], lk[base+2], lc[base+2], lk[base+3], lc[base+3]});
      end else pass_cnt++;
      total_cnt++;
      if (lt[base+2] - lt[base+1] !== 20) begin
         $display("FAIL repeat_gap: got %0d want 20", lt[base+2] - lt[base+1]);
      end else pass_cnt++;
`else
      total_cnt++;
      if (n_log - base !== 3) begin
         $display("FAIL long_count: got %0d want 3", n_log - base);
      end else pass_cnt++;
      total_cnt++;
      if ({lk[base], lc[base], lk[base+1], lc[base+1], lk[base+2], lc[base+2]} !== 9'b1_00_1_10_1_01) begin
         $display("FAIL long_events: got %b want 100110101",
                  {lk[base], lc[base], lk[base+1], lc[base+1], lk[base+2], lc[base+2]});
      end else pass_cnt++;
`endif
      total_cnt++;
      if (lt[base+1] - lt[base] !== 30) begin
         $display("FAIL long_gap: got %0d want 30", lt[base+1] - lt[base]);
      end else pass_cnt++;
   endtask

   task automatic test_release_at_long;
      int base;
      base = n_log;
      stableKey[0] = 1'b1;
      tick(30);
      stableKey[0] = 1'b0;
      tick(6);
      total_cnt++;
      if (n_log - base !== 2) begin
         $display("FAIL release_at_long_count: got %0d want 2", n_log - base);
      end else pass_cnt++;
      total_cnt++;
      if ({lc[base], lc[base+1]} !== 4'b00_01) begin
         $display("FAIL release_at_long_codes: got %b want 0001", {lc[base], lc[base+1]});
      end else pass_cnt++;
   endtask

   task automatic test_simultaneous;
      int base;
      base = n_log;
      stableKey = 2'b11;
      tick(4);
      total_cnt++;
      if (n_log - base !== 2 || {lk[base], lc[base], lk[base+1], lc[base+1]} !== 6'b0_00_1_00) begin
         $display("FAIL simul_press: got n=%0d %b want n=2 000100", n_log - base,
                  {lk[base], lc[base], lk[base+1], lc[base+1]});
      end else pass_cnt++;
      total_cnt++;
      if (lt[base+1] - lt[base] !== 1) begin
         $display("FAIL simul_gap: got %0d want 1", lt[base+1] - lt[base]);
      end else pass_cnt++;
      stableKey = 2'b00;
      tick(6);
      total_cnt++;
      if (n_log - base !== 4 || {lk[base+2], lc[base+2], lk[base+3], lc[base+3]} !== 6'b0_01_1_01) begin
         $display("FAIL simul_release: got n=%0d %b want n=4 001101", n_log - base,
                  {lk[base+2], lc[base+2], lk[base+3], lc[base+3]});
      end else pass_cnt++;
   endtask

   task automatic test_back_pressure;
      int base;
      base = n_log;
      evtReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         stableKey[0] = (i % 2 == 0);
         tick(2);
         if (i == 4) begin
            total_cnt++;
            if (evtOverflow !== 1'b0) begin
               $display("FAIL overflow_early: got %b want 0", evtOverflow);
            end else pass_cnt++;
         end
         if (i >= 1) begin
            total_cnt++;
            if ({evtValid, evtKey, evtCode} !== 4'b1_0_00) begin
               $display("FAIL head_stable_%0d: got %b want 1000", i, {evtValid, evtKey, evtCode});
            end else pass_cnt++;
         end
      end
      total_cnt++;
      if (evtOverflow !== 1'b1) begin
         $display("FAIL overflow_set: got %b want 1", evtOverflow);
      end else pass_cnt++;
      total_cnt++;
      if (n_log !== base) begin
         $display("FAIL no_pop_when_not_ready: got %0d want %0d", n_log, base);
      end else pass_cnt++;
      evtReady = 1'b1;
      tick(10);
      total_cnt++;
      if (n_log - base !== 5 ||
          {lc[base], lc[base+1], lc[base+2], lc[base+3], lc[base+4]} !== 10'b00_01_00_01_00 ||
          {lk[base], lk[base+1], lk[base+2], lk[base+3], lk[base+4]} !== 5'b0) begin
         $display("FAIL drain_order: got n=%0d codes %b want n=5 0001000100", n_log - base,
                  {lc[base], lc[base+1], lc[base+2], lc[base+3], lc[base+4]});
      end else pass_cnt++;
      total_cnt++;
      if ({evtValid, evtOverflow} !== 2'b01) begin
         $display("FAIL after_drain: got %b want 01", {evtValid, evtOverflow});
      end else pass_cnt++;
   endtask

   task automatic test_reset_midflight;
      int base;
      evtReady = 1'b1;
      stableKey[0] = 1'b1;
      tick(4);
      evtReady = 1'b0;
      stableKey[0] = 1'b0;
      tick(2);
      stableKey[0] = 1'b1;
      tick(3);
      total_cnt++;
      if ({evtValid, evtKey, evtCode} !== 4'b1_0_01) begin
         $display("FAIL queued_before_reset: got %b want 1001", {evtValid, evtKey, evtCode});
      end else pass_cnt++;
      #2;
      sysRst = 1'b0;
      #1;
      total_cnt++;
      if ({evtValid, evtOverflow, evtKey, evtCode} !== 5'b0) begin
         $display("FAIL async_reset_clear: got %b want 00000", {evtValid, evtOverflow, evtKey, evtCode});
      end else pass_cnt++;
      evtReady = 1'b1;
      tick(2);
      base = n_log;
      sysRst = 1'b1;
      tick(8);
      total_cnt++;
      if (n_log - base !== 1 || {lk[base], lc[base]} !== 3'b0_00) begin
         $display("FAIL press_after_reset: got n=%0d %b want n=1 000", n_log - base, {lk[base], lc[base]});
      end else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_repeat();
      test_release_at_long();
      test_simultaneous();
      test_back_pressure();
      test_reset_midflight();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_MS, default 50000, meaning sysClk cycles per millisecond (50 MHz).
REQ-002 The block SHALL have parameter LONG_PRESS_MS, default 1000, meaning hold time before a long-press event.
REQ-003 The block SHALL have parameter REPEAT_MS, default 200, meaning the auto-repeat period after a long press.
REQ-004 The block SHALL have port sysClk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port sysRst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port stableKey  input  2  debounced key levels, 1 = pressed.
REQ-007 The block SHALL have port evtValid  output  1  FIFO head holds an event.
REQ-008 The block SHALL have port evtReady  input  1  consumer accepts the head event.
REQ-009 The block SHALL have port evtKey  output  1  key index of the head event.
REQ-010 The block SHALL have port evtCode  output  2  head event code: 0 press, 1 release, 2 long, 3 repeat.
REQ-011 The block SHALL have port evtOverflow  output  1  sticky flag, an event was dropped.

Function
REQ-012 The block SHALL keep per-key state IDLE, PRESSED or HELD, a 32-bit hold counter, a previous-level register, and a one-entry pending-event slot.
REQ-013 The block SHALL load a press event into the key's pending slot and enter PRESSED with counter 0 at edge k, where stableKey is 1 at edge k and 0 at edge k-1.
REQ-014 In PRESSED, the counter SHALL increment each cycle; at count LONG_PRESS_MS*CYCLES_PER_MS-1 the block SHALL emit a long event, enter HELD and clear the counter.
REQ-015 In HELD, the block SHALL emit nothing unless the repeat feature is compiled in (REQ-029).
REQ-016 A falling level in PRESSED or HELD SHALL emit a release event and return to IDLE; when release coincides with the long or repeat threshold, only the release SHALL be emitted.
REQ-017 Pending slots SHALL drain into a 4-entry FIFO at one write per cycle with fixed priority to key 0, and key 1 held pending.
REQ-018 A pending slot SHALL NOT write while the FIFO is full, even if a pop occurs in the same cycle.
REQ-019 When a new event finds its key's pending slot occupied, the new event SHALL be dropped and evtOverflow set.
REQ-020 evtValid SHALL equal FIFO not empty; evtKey and evtCode SHALL present the head entry combinationally.
REQ-021 A pop SHALL occur on a rising edge with evtValid=1 and evtReady=1; evtReady while empty SHALL have no effect.
REQ-022 Head data SHALL remain stable while evtValid=1 and evtReady=0.
REQ-023 FIFO pointers SHALL wrap modulo 4, with a simultaneous push and pop when not full and not empty leaving the count unchanged.
REQ-024 Latency SHALL be: event in pending slot at edge k, FIFO write at edge k+1, evtValid high after edge k+1 when the FIFO was empty.

Reset
REQ-025 Asserting sysRst low at any time SHALL immediately clear all states to IDLE, counters, previous-level registers, pending slots, FIFO pointers, evtValid, evtKey, evtCode and evtOverflow to 0.
REQ-026 The block SHALL discard any in-flight events on reset, and SHALL emit no release event for a key held through reset.
REQ-027 A key still held when reset deasserts SHALL produce a press event on the first clock edge, because its previous level resets to 0.
REQ-028 evtOverflow SHALL clear only by reset.

Configuration
REQ-029 When macro KEY_REPEAT_EN is defined, HELD SHALL count and emit a repeat event every REPEAT_MS*CYCLES_PER_MS cycles until release, with the first repeat one full period after the long event.
REQ-030 When KEY_REPEAT_EN is undefined, the block SHALL omit the repeat logic, never emit code 3, and ignore REPEAT_MS.

Verification (CYCLES_PER_MS=10, LONG_PRESS_MS=3, REPEAT_MS=2, evtReady=1 unless stated)
REQ-031 Bench: stableKey[0] high 5 cycles then low -> events (0,press) and (0,release), no long event.
REQ-032 Bench: stableKey[1] high 60 cycles, KEY_REPEAT_EN defined -> press, long at hold count 29, repeats every 20 cycles, release; undefined -> press, long, release only.
REQ-033 Bench: both keys rise at the same edge -> (0,press) delivered one cycle before (1,press).
REQ-034 Bench: evtReady=0 while 6 events are generated -> 4 events held in the FIFO with stable head, pending slots fill, evtOverflow=1; raising evtReady drains events in order.
REQ-035 Bench: sysRst pulsed low while key 0 is held with 2 events queued -> evtValid=0 immediately; after release of reset, a single (0,press) event is emitted.
